// File: rtl/mul_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
//   DIN_W_DEF / DOUT_W_DEF : default operand / result widths
//   MAX_REQ                : largest supported requester count
//   id_t                   : requester index wide enough for MAX_REQ
//   stage_t                : pipeline stage record at default widths
//   idx_next()             : wrap-around successor used by the RR search
package mul_share_pkg;

    localparam int unsigned DIN_W_DEF  = 12;
    localparam int unsigned DOUT_W_DEF = 12;
    localparam int unsigned MAX_REQ    = 8;

    typedef logic [2:0] id_t;

    typedef struct packed {
        logic                           valid;
        id_t                            id;
        logic signed [DIN_W_DEF-1:0]    a;
        logic signed [DIN_W_DEF-1:0]    b;
        logic signed [DOUT_W_DEF-1:0]   prod;
    } stage_t;

    // Successor of cur in the ring 0..n-1.
    function automatic id_t idx_next(input id_t cur, input int unsigned n);
        if (32'(cur) + 32'd1 >= n) begin
            return '0;
        end
        return id_t'(cur + 1'b1);
    endfunction

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Handshake bundle between the requesters/downstream sink and the shared
// multiplier block.
//   req_valid/req_ready/req_a/req_b : per-requester operand channel
//   out_valid/out_ready/out_data/out_id : shared result channel
//   busy : pipeline occupancy flag
// master = requesters + sink side, slave = mul_share_arbiter side.
interface mul_share_arbiter_if
    import mul_share_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned DIN_W   = DIN_W_DEF,
    parameter int unsigned DOUT_W  = DOUT_W_DEF
) ();

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*DIN_W-1:0] req_a;
    logic [NUM_REQ*DIN_W-1:0] req_b;
    logic                     out_valid;
    logic                     out_ready;
    logic [DOUT_W-1:0]        out_data;
    logic [ID_W-1:0]          out_id;
    logic                     busy;

    modport master (
        output req_valid, req_a, req_b, out_ready,
        input  req_ready, out_valid, out_data, out_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, out_ready,
        output req_ready, out_valid, out_data, out_id, busy
    );

endinterface

// File: rtl/mul_share_arbiter_rr_arb.sv
// Round-robin arbiter for the shared multiplier.
//   ap_clk, ap_rst_n : clock, async active-low reset
//   req_valid_i      : per-requester request
//   adv_i            : pipeline can accept this cycle (pointer moves only then)
//   grant_o          : one-hot grant (not qualified by adv_i)
//   gnt_any_o        : some requester is granted
//   gnt_idx_o        : index of the granted requester
//   ptr_o            : round-robin pointer (last granted index)
module mul_share_rr_arb
    import mul_share_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic               adv_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               gnt_any_o,
    output logic [ID_W-1:0]    gnt_idx_o,
    output logic [ID_W-1:0]    ptr_o
);

    logic [MAX_REQ-1:0] vld_ext;
    id_t                ptr_q;
    id_t                ptr_d;
    id_t                idx;
    id_t                gnt_idx;
    logic               found;

    // Widen so any id_t value is a legal index regardless of NUM_REQ.
    assign vld_ext = MAX_REQ'(req_valid_i);

    // Search starts one past the pointer and wraps; first hit wins.
    always_comb begin
        found   = 1'b0;
        gnt_idx = ptr_q;
        idx     = ptr_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = idx_next(idx, NUM_REQ);
            if (!found && vld_ext[idx]) begin
                found   = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (found && adv_i) begin
            ptr_d = gnt_idx;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr_q <= id_t'(NUM_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign grant_o   = found ? NUM_REQ'(MAX_REQ'(1) << gnt_idx) : '0;
    assign gnt_any_o = found;
    assign gnt_idx_o = ID_W'(gnt_idx);
    assign ptr_o     = ID_W'(ptr_q);

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one signed DIN_W x DIN_W multiplier (DOUT_W-bit truncated product)
// among NUM_REQ requesters through a stallable MUL_STAGES pipeline.
//   ap_clk, ap_rst_n : clock, async active-low reset
//   bus (slave)      : requester channels, result channel, busy
// Stage 1 captures id/a/b; the product is formed from the stage-1 operands
// and registered through stages 2..MUL_STAGES. All stages shift together.
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_W       = 2,
    parameter int unsigned DIN_W      = DIN_W_DEF,
    parameter int unsigned DOUT_W     = DOUT_W_DEF,
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    mul_share_arbiter_if.slave  bus
);

    localparam int unsigned LAST = MUL_STAGES - 1;

    logic [NUM_REQ-1:0]               grant;
    logic                             gnt_any;
    logic [ID_W-1:0]                  gnt_idx;
    logic [ID_W-1:0]                  rr_ptr;
    logic                             adv;
    logic                             adv_en;
    logic                             hs;
    logic signed [DIN_W-1:0]          a_sel;
    logic signed [DIN_W-1:0]          b_sel;

    logic [MUL_STAGES-1:0]            vld_q;
    logic [MUL_STAGES-1:0][ID_W-1:0]  id_q;
    logic signed [DIN_W-1:0]          a_q;
    logic signed [DIN_W-1:0]          b_q;
    logic [DOUT_W-1:0]                prod_s1;
    logic [DOUT_W-1:0]                prod_last;

    assign adv    = !(vld_q[LAST] && !bus.out_ready);
    // Accepts are suppressed while reset is asserted so req_ready reads 0.
    assign adv_en = adv && ap_rst_n;
    assign hs     = gnt_any && adv_en;

    mul_share_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .req_valid_i (bus.req_valid),
        .adv_i       (adv_en),
        .grant_o     (grant),
        .gnt_any_o   (gnt_any),
        .gnt_idx_o   (gnt_idx),
        .ptr_o       (rr_ptr)
    );

    assign bus.req_ready = grant & {NUM_REQ{adv_en}};

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                a_sel = bus.req_a[i*DIN_W +: DIN_W];
                b_sel = bus.req_b[i*DIN_W +: DIN_W];
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_q <= '0;
            id_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else if (adv) begin
            vld_q[0] <= hs;
            for (int unsigned k = 1; k < MUL_STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
                id_q[k]  <= id_q[k-1];
            end
            if (hs) begin
                id_q[0] <= gnt_idx;
                a_q     <= a_sel;
                b_q     <= b_sel;
            end
        end
    end

    // Sign-extending both operands to DOUT_W before multiplying yields the
    // low DOUT_W bits of the full signed product without a wide temporary.
    assign prod_s1 = DOUT_W'(a_q) * DOUT_W'(b_q);

    if (MUL_STAGES == 1) begin : g_comb
        assign prod_last = prod_s1;
    end else begin : g_pipe
        logic [MUL_STAGES-1:1][DOUT_W-1:0] prod_q;

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                prod_q <= '0;
            end else if (adv) begin
                prod_q[1] <= prod_s1;
                for (int unsigned k = 2; k < MUL_STAGES; k++) begin
                    prod_q[k] <= prod_q[k-1];
                end
            end
        end

        assign prod_last = prod_q[MUL_STAGES-1];
    end

    assign bus.out_valid = vld_q[LAST];
    assign bus.out_data  = prod_last;
    assign bus.out_id    = id_q[LAST];
    assign bus.busy      = |vld_q;

    // After an accept the pointer must name the requester just granted.
    a_ptr_follows_grant: assert property (
        @(posedge ap_clk) disable iff (!ap_rst_n)
        hs |=> (rr_ptr == $past(gnt_idx))
    );

endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;

    localparam int N  = 4;
    localparam int S  = 2;
    localparam int DW = 12;

    logic ap_clk = 1'b0;
    logic ap_rst_n;

    always #5 ap_clk = ~ap_clk;

    mul_share_arbiter_if #(.NUM_REQ(N), .ID_W(2), .DIN_W(DW), .DOUT_W(DW)) bus ();

    mul_share_arbiter #(
        .NUM_REQ    (N),
        .ID_W       (2),
        .DIN_W      (DW),
        .DOUT_W     (DW),
        .MUL_STAGES (S)
    ) dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;

    // Requester operand sources (signed integer values).
    int in_a [N];
    int in_b [N];

    // Reference model: S result slots that shift whenever the pipe advances.
    int m_ptr;
    bit m_v  [S];
    int m_id [S];
    int m_d  [S];
    bit m_adv;
    bit m_pop;
    int m_g;
    int issued = 0;
    int popped = 0;
    int held_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
        end
    endtask

    function automatic int pick();
        case ($urandom_range(0, 7))
            0:       return -2048;
            1:       return 2047;
            2:       return -1;
            default: return int'($urandom_range(0, 4095)) - 2048;
        endcase
    endfunction

    task automatic new_ops(input int i);
        in_a[i] = pick();
        in_b[i] = pick();
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_a[i*DW +: DW] = DW'(in_a[i]);
            bus.req_b[i*DW +: DW] = DW'(in_b[i]);
        end
    endtask

    task automatic m_reset();
        m_ptr = N - 1;
        m_g   = -1;
        m_adv = 1'b0;
        m_pop = 1'b0;
        for (int k = 0; k < S; k++) begin
            m_v[k]  = 1'b0;
            m_id[k] = 0;
            m_d[k]  = 0;
        end
    endtask

    // Compare DUT outputs against the model mid-cycle, and decide the grant.
    task automatic sample();
        bit ov;
        bit anyv;
        int exp_rdy;
        @(negedge ap_clk);
        ov   = m_v[S-1];
        anyv = 1'b0;
        for (int k = 0; k < S; k++) anyv = anyv | m_v[k];
        chk("out_valid", 32'(bus.out_valid), 32'(ov));
        chk("busy", 32'(bus.busy), 32'(anyv));
        if (ov) begin
            chk("out_data", 32'(bus.out_data), m_d[S-1]);
            chk("out_id", 32'(bus.out_id), m_id[S-1]);
        end
        m_adv = !(ov && !bus.out_ready);
        m_pop = ov && bus.out_ready;
        m_g   = -1;
        if (m_adv) begin
            for (int k = 1; k <= N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (m_g < 0 && bus.req_valid[i]) m_g = i;
            end
        end
        exp_rdy = (m_g >= 0) ? (1 << m_g) : 0;
        chk("req_ready", 32'(bus.req_ready), exp_rdy);
    endtask

    task automatic advance();
        @(posedge ap_clk);
        if (m_adv) begin
            for (int k = S - 1; k > 0; k--) begin
                m_v[k]  = m_v[k-1];
                m_id[k] = m_id[k-1];
                m_d[k]  = m_d[k-1];
            end
            m_v[0] = (m_g >= 0);
            if (m_g >= 0) begin
                m_id[0] = m_g;
                m_d[0]  = (in_a[m_g] * in_b[m_g]) & 32'hFFF;
                m_ptr   = m_g;
                issued++;
            end
        end
        if (m_pop) popped++;
        #1;
    endtask

    task automatic step();
        drive();
        sample();
        advance();
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        m_reset();
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        chk("rst_out_id", 32'(bus.out_id), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        @(posedge ap_clk);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
    endtask

    task automatic directed(input int a, input int b, input int want);
        in_a[0] = a;
        in_b[0] = b;
        bus.req_valid = 4'b0001;
        drive();
        sample();
        chk("dir_accept", 32'(bus.req_ready), 1);
        advance();
        bus.req_valid = '0;
        for (int c = 1; c < S; c++) begin
            sample();
            chk("dir_early", 32'(bus.out_valid), 0);
            advance();
        end
        sample();
        chk("dir_valid", 32'(bus.out_valid), 1);
        chk("dir_data", 32'(bus.out_data), want);
        chk("dir_id", 32'(bus.out_id), 0);
        advance();
    endtask

    initial begin
        ap_rst_n      = 1'b1;
        bus.out_ready = 1'b1;
        bus.req_valid = '1;
        for (int i = 0; i < N; i++) begin
            in_a[i] = i + 1;
            in_b[i] = i + 2;
        end
        drive();
        #6;

        // Reset state with every requester asking.
        do_reset();
        bus.req_valid = '0;

        // Directed products on requester 0, including wrap boundaries.
        directed(3, 4, 'h00C);
        directed(-5, 7, 'hFDD);
        directed(2047, 2047, 'h001);
        directed(-2048, -2048, 'h000);
        directed(-2048, 1, 'h800);
        directed(-1, -1, 'h001);

        // Round-robin over all four requesters.
        do_reset();
        for (int c = 0; c < 8 + S; c++) begin
            bus.req_valid = (c < 8) ? 4'hF : 4'h0;
            drive();
            sample();
            if (c < 8) chk("rr_grant", 32'(bus.req_ready), 1 << (c % 4));
            if (c >= S) begin
                chk("rr_out_valid", 32'(bus.out_valid), 1);
                chk("rr_out_id", 32'(bus.out_id), (c - S) % 4);
            end
            advance();
            if (m_g >= 0) new_ops(m_g);
        end

        // Backpressure: stream on requester 2, then stall the sink for 5 cycles.
        bus.req_valid = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            step();
            if (m_g >= 0) new_ops(m_g);
        end
        bus.out_ready = 1'b0;
        held_d = 0;
        for (int c = 0; c < 5; c++) begin
            drive();
            sample();
            if (c == 0) held_d = m_d[S-1];
            chk("bp_ready", 32'(bus.req_ready), 0);
            chk("bp_valid", 32'(bus.out_valid), 1);
            chk("bp_hold_data", 32'(bus.out_data), held_d);
            chk("bp_hold_id", 32'(bus.out_id), 2);
            advance();
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < S + 4; c++) begin
            bus.req_valid = (c < 4) ? 4'b0100 : 4'b0000;
            drive();
            sample();
            chk("bp_flow", 32'(bus.out_valid), 1);
            advance();
            if (m_g >= 0) new_ops(m_g);
        end
        chk("bp_count", issued, popped);

        // Sparse: requesters 1 and 3 alternate.
        do_reset();
        bus.req_valid = 4'b1010;
        for (int c = 0; c < 4; c++) begin
            drive();
            sample();
            chk("sp_alt", 32'(bus.req_ready), (c % 2 == 0) ? 2 : 8);
            advance();
            if (m_g >= 0) new_ops(m_g);
        end
        bus.req_valid = '0;
        for (int c = 0; c < S; c++) step();

        // Only requester 3 right after reset.
        do_reset();
        bus.req_valid = 4'b1000;
        drive();
        sample();
        chk("sp_first3", 32'(bus.req_ready), 8);
        advance();
        bus.req_valid = '0;
        for (int c = 0; c < S; c++) step();

        // Reset with two entries in flight.
        bus.req_valid = 4'b0001;
        step();
        new_ops(0);
        step();
        bus.req_valid = 4'hF;
        drive();
        #2;
        do_reset();
        drive();
        sample();
        chk("mf_first", 32'(bus.req_ready), 1);
        advance();
        bus.req_valid = '0;
        for (int c = 0; c < S + 2; c++) step();
        issued = 0;
        popped = 0;

        // Randomized traffic with random sink backpressure.
        for (int c = 0; c < 400; c++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) begin
                    bus.req_valid[i] = 1'b1;
                    new_ops(i);
                end
            end
            step();
            if (m_g >= 0) begin
                new_ops(m_g);
                bus.req_valid[m_g] = $urandom_range(0, 1) != 0;
            end
        end
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < S + 4; c++) step();
        chk("final_count", issued, popped);
        chk("final_idle", 32'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one signed 12x12 multiplier (12-bit truncated product, the mul_12s_12s_12 operator class) among NUM_REQ requesters.
- Each requester issues operand pairs over a valid/ready handshake. The block picks one per cycle by round-robin and pushes the pair through a stallable MUL_STAGES pipeline.
- It returns each product with the originating requester ID on one shared result port.
- Sits between HLS compute lanes and the single multiplier resource to cut DSP count.

Parameters:
- NUM_REQ, 4: number of requesters, range 2..8.
- ID_W, 2: width of out_id; must satisfy 2^ID_W >= NUM_REQ.
- DIN_W, 12: width of each signed operand.
- DOUT_W, 12: result width; low DOUT_W bits of the full signed product.
- MUL_STAGES, 2: pipeline depth, range 1..4.

Ports:
- ap_clk  in  1  clock; all state updates on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit set per cycle.
- req_a  in  NUM_REQ*DIN_W  packed signed operand A; requester i occupies bits [i*DIN_W +: DIN_W].
- req_b  in  NUM_REQ*DIN_W  packed signed operand B, same packing as req_a.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  DOUT_W  truncated signed product.
- out_id  out  ID_W  index of the requester that issued the operands.
- busy  out  1  high while any pipeline stage holds a valid entry.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All stage valid bits = 0; out_valid = 0, out_data = 0, out_id = 0, busy = 0, req_ready = 0.
  - RR pointer = NUM_REQ-1, so requester 0 has top priority first.
  - Reset mid-operation discards all in-flight entries. No result is emitted for them.
- Pipeline:
  - Stage k holds {valid, id, payload}.
  - Stage 1 registers id, a and b on acceptance. The product is formed combinationally from the stage-1 operands and registered in stages 2..MUL_STAGES.
  - MUL_STAGES = 1: product drives out_data combinationally from stage 1.
- Stall rule:
  - adv = !(stage_last.valid && !out_ready).
  - When adv = 0, every stage holds. When adv = 1, all stages shift one position. Bubbles are not compressed.
- Arbitration:
  - grant = first i with req_valid[i], searching from (ptr+1) mod NUM_REQ upward with wrap.
  - req_ready[i] = grant[i] & adv.
  - On handshake, ptr <= granted index. With no requests, ptr is unchanged.
  - Requesters must not gate req_valid on req_ready, and must hold operands stable until accepted.
- Latency and throughput:
  - Handshake in cycle t: out_valid is high in cycle t+MUL_STAGES if no stall occurs.
  - Throughput is one result per cycle; results return in issue order.
- Arithmetic:
  - full = $signed(a) * $signed(b), 2*DIN_W bits.
  - out_data = full[DOUT_W-1:0]; wraps with no saturation.
- Output:
  - out_data and out_id remain stable while out_valid && !out_ready.
  - out_valid never drops without a handshake, except on reset.
- busy = OR of all stage valid bits.
- Boundary cases:
  - Full pipe with out_ready low: req_ready = 0 for all requesters, and no entry is lost or duplicated.
  - Simultaneous output pop and input accept in one cycle is legal and keeps throughput at one per cycle.
  - A single requester valid for N consecutive cycles is granted every cycle.

Decomposition:
- Shared package mul_share_pkg holds:
  - DIN_W and DOUT_W defaults.
  - An id_t typedef.
  - A stage record typedef {valid, id, a, b, prod}.
  - An idx_next function implementing the wrap-around search for the arbiter.
- One sub-module: mul_share_rr_arb.
  - Inputs: req_valid, adv.
  - Outputs: one-hot grant, granted index, and the RR pointer register.
- The top module instantiates the arbiter and holds the pipeline registers and multiply.

Test Plan:
- Basic products, requester 0 only, default params: (3,4) -> out_data=0x00C and out_id=0 exactly 2 cycles after the handshake. (-5,7) -> out_data=0xFDD.
- Wrap boundaries: (2047,2047) -> 0x001. (-2048,-2048) -> 0x000. (-2048,1) -> 0x800. (-1,-1) -> 0x001.
- Round-robin: all 4 requesters held valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3. out_id follows the same order, one result per cycle.
- Backpressure: stream on requester 2, drop out_ready for 5 cycles.
  - Pipe fills, all req_ready = 0, out_data held stable.
  - On release, every result emerges exactly once, in order, with no gaps from that point.
- Sparse arbitration: only requesters 1 and 3 valid -> grants alternate 1,3,1,3. Starting from reset with only requester 3 valid -> immediate grant to 3.
- Reset mid-flight: assert ap_rst_n=0 with 2 entries in flight -> out_valid and busy drop asynchronously. After release, the first request goes to requester 0 and no stale result appears.
